ascon_block_padder: RTL and testbench
=====================================

ASCON_BLOCK_PADDER -- requirements
Module: ascon_block_padder

Interface
REQ-001 The block SHALL have parameter PAD_BYTE, default 8'h80, the byte written immediately after the last message byte.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port reset, input, 1, the reset, which is synchronous and active-high.
REQ-004 The block SHALL have port i_sys_enable, input, 1, system enable; low means synchronous soft clear.
REQ-005 The block SHALL have port i_byte_valid, input, 1, input byte valid.
REQ-006 The block SHALL have port i_byte_data, input, 8, input message byte.
REQ-007 The block SHALL have port i_byte_last, input, 1, marks the final byte of the message.
REQ-008 The block SHALL have port i_msg_empty, input, 1, qualifies a last beat as a zero-length message; i_byte_data is ignored.
REQ-009 The block SHALL have port o_byte_ready, output, 1, byte accept.
REQ-010 The block SHALL have port o_block_valid, output, 1, 64-bit block available.
REQ-011 The block SHALL have port o_block_data, output, 64, padded block feeding the permutation data input.
REQ-012 The block SHALL have port o_block_last, output, 1, final block of the message.
REQ-013 The block SHALL have port o_block_pad_only, output, 1, block holds padding only.
REQ-014 The block SHALL have port i_block_ready, input, 1, downstream accept.

Function
REQ-015 A byte SHALL transfer only in a cycle where i_byte_valid and o_byte_ready are both high.
REQ-016 A block SHALL transfer only in a cycle where o_block_valid and i_block_ready are both high.
REQ-017 Packing SHALL be big-endian: message byte n of a block goes to bits [63-8n -: 8], for n = 0..7.
REQ-018 The FSM SHALL have these states: ST_FILL, ST_OUT and ST_PAD.
- o_byte_ready is high only in ST_FILL.
- o_block_valid is high only in ST_OUT and ST_PAD.
REQ-019 In ST_FILL, accepting the 8th byte with last=0 SHALL go to ST_OUT with o_block_last=0.
REQ-020 In ST_FILL, accepting a last byte that leaves k<8 bytes in the block SHALL:
- put PAD_BYTE at lane k;
- zero the remaining lanes;
- go to ST_OUT with o_block_last=1.
REQ-021 In ST_FILL, accepting a last byte that fills lane 7 SHALL go to ST_OUT with o_block_last=0, then take ST_OUT -> ST_PAD on block transfer.
REQ-022 ST_PAD SHALL present {PAD_BYTE, 56'h0} with o_block_last=1 and o_block_pad_only=1.
REQ-023 A last beat with i_msg_empty=1 at byte count 0 SHALL go directly to ST_PAD; with i_msg_empty=1 at count>0, it SHALL close the block as in REQ-020 with k = the current count.
REQ-024 On a block transfer in ST_OUT or ST_PAD, the FSM SHALL return to ST_FILL with count 0 and data cleared, unless REQ-021 applies.
REQ-025 Latency SHALL be 1 cycle: o_block_valid rises the cycle after the closing byte transfer.
REQ-026 Throughput SHALL be at most 8 bytes per 9 cycles.
REQ-027 o_block_data, o_block_last and o_block_pad_only SHALL be stable while o_block_valid=1 and i_block_ready=0.
REQ-028 Byte valid and block ready high in the same cycle SHALL transfer the block only; the byte is accepted in the next cycle at the earliest.
REQ-029 The byte counter SHALL be 4 bits, range 0..8, and never wrap.

Reset
REQ-030 On reset=1 at a clock edge, the block SHALL set:
- state ST_FILL and count 0;
- o_block_data=64'h0;
- o_block_valid=0, o_block_last=0, o_block_pad_only=0;
- o_byte_ready=1 after release.
REQ-031 i_sys_enable=0 SHALL have the same effect as reset; reset has priority.
REQ-032 Reset or soft clear during an operation SHALL discard the partial block and any pending block.

Configuration
REQ-033 With ASCON_PADDER_COUNT_EN defined, the block SHALL add output o_msg_bytes, 16 bits, with this behaviour:
- counts accepted non-empty bytes of the current message;
- saturates at 16'hFFFF;
- clears on the first byte of a new message and on reset;
- holds its value after the last byte.
REQ-034 Without ASCON_PADDER_COUNT_EN, the port and counter SHALL be absent and the other behaviour SHALL be unchanged.

Structure
REQ-035 ascon_pkg SHALL hold the following:
- the enum t_padder_state {ST_FILL, ST_OUT, ST_PAD};
- ASCON_BLOCK_BYTES = 8;
- ASCON_PAD_BYTE = 8'h80, used as the PAD_BYTE default.
REQ-036 The block SHALL be a single module with no sub-module; lane insertion is an indexed write within the module.

Verification
REQ-037 Bytes 01,02,03 (last on 03) SHALL give one block 0x0102038000000000, last=1, pad_only=0.
REQ-038 Bytes 00..07 (last on 07) SHALL give 0x0001020304050607 with last=0, then 0x8000000000000000 with last=1, pad_only=1.
REQ-039 A single beat with i_msg_empty=1 and i_byte_last=1 SHALL give 0x8000000000000000, last=1, pad_only=1.
REQ-040 The 11 bytes 00..0A, with i_block_ready held low 5 cycles on each block, SHALL give:
- a full block with last=0, then 0x08090A8000000000 with last=1;
- block data stable and o_byte_ready=0 while stalled;
- o_msg_bytes=11 when ASCON_PADDER_COUNT_EN is defined.
REQ-041 Reset=1 for one cycle after 4 bytes SHALL clear all outputs to 0; the next byte, 0xAA, SHALL land in bits [63:56].
REQ-042 i_sys_enable=0 while a block is held in ST_OUT SHALL drop o_block_valid and clear o_block_data next cycle; no block is emitted.

Source files
------------

// File: rtl/ascon_pkg.sv
// ============================================================================
// Module      : ascon_pkg
// Description : Shared state encoding and constants for the Ascon block padder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ascon_pkg;

    localparam int unsigned ASCON_BLOCK_BYTES = 8;
    localparam logic [7:0]  ASCON_PAD_BYTE    = 8'h80;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_OUT  = 2'd1,
        ST_PAD  = 2'd2
    } t_padder_state;

endpackage : ascon_pkg

`default_nettype wire

// File: rtl/ascon_block_padder.sv
// ============================================================================
// Module      : ascon_block_padder
// Description : Packs a byte stream big-endian into 64-bit blocks and applies
//               Ascon 10* padding. Optional macro ASCON_PADDER_COUNT_EN adds
//               the o_msg_bytes message byte counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

import ascon_pkg::*;

module ascon_block_padder #(
    parameter logic [7:0] PAD_BYTE = ASCON_PAD_BYTE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_sys_enable,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte_data,
    input  logic        i_byte_last,
    input  logic        i_msg_empty,
    output logic        o_byte_ready,
    output logic        o_block_valid,
    output logic [63:0] o_block_data,
    output logic        o_block_last,
    output logic        o_block_pad_only,
    input  logic        i_block_ready
`ifdef ASCON_PADDER_COUNT_EN
    ,
    output logic [15:0] o_msg_bytes
`endif
);

    localparam logic [63:0] c_PAD_BLOCK = {PAD_BYTE, 56'h0};

    t_padder_state r_state;
    logic [3:0]    r_count;
    logic [63:0]   r_data;
    logic          r_byte_ready;
    logic          r_block_valid;
    logic          r_block_last;
    logic          r_pad_only;
    logic          r_pend_pad;

    logic          w_byte_xfer;
    logic          w_block_xfer;
    logic          w_empty_beat;
    logic [5:0]    w_lane_lo;
    logic [5:0]    w_next_lo;
    logic [63:0]   w_fill_data;
    logic [63:0]   w_close_data;
    logic [63:0]   w_empty_data;

    assign w_byte_xfer  = i_byte_valid & r_byte_ready;
    assign w_block_xfer = r_block_valid & i_block_ready;
    assign w_empty_beat = i_byte_last & i_msg_empty;

    // Lane n sits at bits [63-8n -: 8]; only lanes 0..7 are addressed in ST_FILL.
    assign w_lane_lo = {3'd7 - r_count[2:0], 3'b000};
    assign w_next_lo = {3'd6 - r_count[2:0], 3'b000};

    always_comb begin
        w_fill_data                   = r_data;
        w_fill_data[w_lane_lo +: 8]   = i_byte_data;
        w_close_data                  = w_fill_data;
        if (r_count != 4'd7) begin
            w_close_data[w_next_lo +: 8] = PAD_BYTE;
        end
        w_empty_data                  = r_data;
        w_empty_data[w_lane_lo +: 8]  = PAD_BYTE;
    end

    always_ff @(posedge clock) begin
        if (reset || !i_sys_enable) begin
            r_state       <= ST_FILL;
            r_count       <= 4'd0;
            r_data        <= 64'h0;
            r_byte_ready  <= 1'b1;
            r_block_valid <= 1'b0;
            r_block_last  <= 1'b0;
            r_pad_only    <= 1'b0;
            r_pend_pad    <= 1'b0;
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (w_byte_xfer) begin
                        if (w_empty_beat && r_count == 4'd0) begin
                            r_state       <= ST_PAD;
                            r_data        <= c_PAD_BLOCK;
                            r_byte_ready  <= 1'b0;
                            r_block_valid <= 1'b1;
                            r_block_last  <= 1'b1;
                            r_pad_only    <= 1'b1;
                        end else if (w_empty_beat) begin
                            r_state       <= ST_OUT;
                            r_data        <= w_empty_data;
                            r_byte_ready  <= 1'b0;
                            r_block_valid <= 1'b1;
                            r_block_last  <= 1'b1;
                        end else if (i_byte_last) begin
                            // A last byte in lane 7 leaves no room for padding,
                            // so a padding-only block follows.
                            r_state       <= ST_OUT;
                            r_count       <= r_count + 4'd1;
                            r_data        <= w_close_data;
                            r_byte_ready  <= 1'b0;
                            r_block_valid <= 1'b1;
                            r_block_last  <= (r_count != 4'd7);
                            r_pend_pad    <= (r_count == 4'd7);
                        end else if (r_count == 4'd7) begin
                            r_state       <= ST_OUT;
                            r_count       <= 4'd8;
                            r_data        <= w_fill_data;
                            r_byte_ready  <= 1'b0;
                            r_block_valid <= 1'b1;
                            r_block_last  <= 1'b0;
                        end else begin
                            r_count       <= r_count + 4'd1;
                            r_data        <= w_fill_data;
                        end
                    end
                end
                ST_OUT: begin
                    if (w_block_xfer) begin
                        if (r_pend_pad) begin
                            r_state      <= ST_PAD;
                            r_data       <= c_PAD_BLOCK;
                            r_block_last <= 1'b1;
                            r_pad_only   <= 1'b1;
                            r_pend_pad   <= 1'b0;
                        end else begin
                            r_state       <= ST_FILL;
                            r_count       <= 4'd0;
                            r_data        <= 64'h0;
                            r_byte_ready  <= 1'b1;
                            r_block_valid <= 1'b0;
                            r_block_last  <= 1'b0;
                            r_pad_only    <= 1'b0;
                        end
                    end
                end
                ST_PAD: begin
                    if (w_block_xfer) begin
                        r_state       <= ST_FILL;
                        r_count       <= 4'd0;
                        r_data        <= 64'h0;
                        r_byte_ready  <= 1'b1;
                        r_block_valid <= 1'b0;
                        r_block_last  <= 1'b0;
                        r_pad_only    <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= ST_FILL;
                    r_count       <= 4'd0;
                    r_data        <= 64'h0;
                    r_byte_ready  <= 1'b1;
                    r_block_valid <= 1'b0;
                    r_block_last  <= 1'b0;
                    r_pad_only    <= 1'b0;
                    r_pend_pad    <= 1'b0;
                end
            endcase
        end
    end

    assign o_byte_ready     = r_byte_ready;
    assign o_block_valid    = r_block_valid;
    assign o_block_data     = r_data;
    assign o_block_last     = r_block_last;
    assign o_block_pad_only = r_pad_only;

`ifdef ASCON_PADDER_COUNT_EN
    logic [15:0] r_msg_bytes;
    logic        r_msg_start;
    logic [15:0] w_msg_base;

    // The first beat of each message restarts the count from zero.
    assign w_msg_base = r_msg_start ? 16'h0 : r_msg_bytes;

    always_ff @(posedge clock) begin
        if (reset || !i_sys_enable) begin
            r_msg_bytes <= 16'h0;
            r_msg_start <= 1'b1;
        end else if (w_byte_xfer) begin
            r_msg_start <= i_byte_last;
            if (w_empty_beat || w_msg_base == 16'hFFFF) begin
                r_msg_bytes <= w_msg_base;
            end else begin
                r_msg_bytes <= w_msg_base + 16'd1;
            end
        end
    end

    assign o_msg_bytes = r_msg_bytes;
`endif

endmodule : ascon_block_padder

`default_nettype wire

// File: tb/tb_ascon_block_padder.sv
// ============================================================================
// Module      : tb_ascon_block_padder
// Description : Directed self-checking bench for ascon_block_padder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ascon_block_padder;

    logic        clock;
    logic        reset;
    logic        i_sys_enable;
    logic        i_byte_valid;
    logic [7:0]  i_byte_data;
    logic        i_byte_last;
    logic        i_msg_empty;
    logic        o_byte_ready;
    logic        o_block_valid;
    logic [63:0] o_block_data;
    logic        o_block_last;
    logic        o_block_pad_only;
    logic        i_block_ready;
`ifdef ASCON_PADDER_COUNT_EN
    logic [15:0] o_msg_bytes;
`endif

    int checks   = 0;
    int failures = 0;

    ascon_block_padder dut (
        .clock            (clock),
        .reset            (reset),
        .i_sys_enable     (i_sys_enable),
        .i_byte_valid     (i_byte_valid),
        .i_byte_data      (i_byte_data),
        .i_byte_last      (i_byte_last),
        .i_msg_empty      (i_msg_empty),
        .o_byte_ready     (o_byte_ready),
        .o_block_valid    (o_block_valid),
        .o_block_data     (o_block_data),
        .o_block_last     (o_block_last),
        .o_block_pad_only (o_block_pad_only),
        .i_block_ready    (i_block_ready)
`ifdef ASCON_PADDER_COUNT_EN
        ,
        .o_msg_bytes      (o_msg_bytes)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Offers one byte and holds it until accepted.
    task automatic send_byte(input logic [7:0] d, input logic last, input logic empty);
        int waited;
        waited       = 0;
        i_byte_valid = 1'b1;
        i_byte_data  = d;
        i_byte_last  = last;
        i_msg_empty  = empty;
        while (!o_byte_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!o_byte_ready) chk("byte_ready_timeout", 64'd0, 64'd1);
        tick();
        i_byte_valid = 1'b0;
        i_byte_last  = 1'b0;
        i_msg_empty  = 1'b0;
    endtask

    // Waits for a block, checks it, holds it stalled, then accepts it.
    task automatic take_block(input string tag, input logic [63:0] exp_d,
                              input logic exp_last, input logic exp_pad, input int stall);
        int waited;
        waited = 0;
        while (!o_block_valid && waited < 50) begin
            tick();
            waited++;
        end
        chk({tag, "_valid"}, 64'(o_block_valid), 64'd1);
        chk({tag, "_data"},  o_block_data, exp_d);
        chk({tag, "_last"},  64'(o_block_last), 64'(exp_last));
        chk({tag, "_pad"},   64'(o_block_pad_only), 64'(exp_pad));
        for (int i = 0; i < stall; i++) begin
            tick();
            chk({tag, "_stall_data"},  o_block_data, exp_d);
            chk({tag, "_stall_last"},  64'(o_block_last), 64'(exp_last));
            chk({tag, "_stall_valid"}, 64'(o_block_valid), 64'd1);
            chk({tag, "_stall_bready"}, 64'(o_byte_ready), 64'd0);
        end
        i_block_ready = 1'b1;
        tick();
        i_block_ready = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        i_sys_enable  = 1'b1;
        i_byte_valid  = 1'b0;
        i_byte_data   = 8'h00;
        i_byte_last   = 1'b0;
        i_msg_empty   = 1'b0;
        i_block_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        chk("rst_valid", 64'(o_block_valid), 64'd0);
        chk("rst_data",  o_block_data, 64'h0);
        chk("rst_last",  64'(o_block_last), 64'd0);
        chk("rst_pad",   64'(o_block_pad_only), 64'd0);
        chk("rst_bready", 64'(o_byte_ready), 64'd1);

        // Three bytes, padded in lane 3; block appears the cycle after the last byte.
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h03, 1'b1, 1'b0);
        chk("lat_valid", 64'(o_block_valid), 64'd1);
        take_block("b3", 64'h0102038000000000, 1'b1, 1'b0, 0);
        chk("b3_after_bready", 64'(o_byte_ready), 64'd1);
        chk("b3_after_valid",  64'(o_block_valid), 64'd0);

        // Full final block forces a padding-only block.
        for (int i = 0; i < 8; i++) send_byte(8'(i), (i == 7), 1'b0);
        take_block("f8", 64'h0001020304050607, 1'b0, 1'b0, 0);
        take_block("f8pad", 64'h8000000000000000, 1'b1, 1'b1, 0);

        // Zero-length message.
        send_byte(8'hFF, 1'b1, 1'b1);
        take_block("empty", 64'h8000000000000000, 1'b1, 1'b1, 0);
`ifdef ASCON_PADDER_COUNT_EN
        chk("empty_msg_bytes", 64'(o_msg_bytes), 64'd0);
`endif

        // Eleven bytes with downstream stalls.
        for (int i = 0; i < 11; i++) begin
            send_byte(8'(i), (i == 10), 1'b0);
            if (i == 7) take_block("s11a", 64'h0001020304050607, 1'b0, 1'b0, 5);
        end
`ifdef ASCON_PADDER_COUNT_EN
        chk("s11_msg_bytes", 64'(o_msg_bytes), 64'd11);
`endif
        take_block("s11b", 64'h08090A8000000000, 1'b1, 1'b0, 5);
`ifdef ASCON_PADDER_COUNT_EN
        chk("s11_msg_hold", 64'(o_msg_bytes), 64'd11);
`endif

        // Empty last beat at count 2 closes the block at lane 2.
        send_byte(8'h05, 1'b0, 1'b0);
        send_byte(8'h06, 1'b0, 1'b0);
        send_byte(8'h77, 1'b1, 1'b1);
        take_block("empty_k2", 64'h0506800000000000, 1'b1, 1'b0, 0);

        // Reset mid-block discards the partial data.
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        send_byte(8'h33, 1'b0, 1'b0);
        send_byte(8'h44, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_data",  o_block_data, 64'h0);
        chk("mid_rst_valid", 64'(o_block_valid), 64'd0);
        chk("mid_rst_last",  64'(o_block_last), 64'd0);
        chk("mid_rst_pad",   64'(o_block_pad_only), 64'd0);
        chk("mid_rst_bready", 64'(o_byte_ready), 64'd1);
        send_byte(8'hAA, 1'b0, 1'b0);
        chk("aa_lane0", o_block_data, 64'hAA00000000000000);
        send_byte(8'hBB, 1'b1, 1'b0);
        take_block("aa", 64'hAABB800000000000, 1'b1, 1'b0, 0);

        // Soft clear while a full block is held.
        for (int i = 0; i < 8; i++) send_byte(8'(8'hC0 + i), 1'b0, 1'b0);
        chk("held_valid", 64'(o_block_valid), 64'd1);
        chk("held_data",  o_block_data, 64'hC0C1C2C3C4C5C6C7);
        i_sys_enable = 1'b0;
        tick();
        i_sys_enable = 1'b1;
        chk("clr_valid", 64'(o_block_valid), 64'd0);
        chk("clr_data",  o_block_data, 64'h0);
        chk("clr_bready", 64'(o_byte_ready), 64'd1);
        i_block_ready = 1'b1;
        tick();
        tick();
        chk("clr_no_block", 64'(o_block_valid), 64'd0);
        i_block_ready = 1'b0;

        // Block still pending while a byte is offered: byte waits for the block.
        send_byte(8'h5A, 1'b1, 1'b0);
        i_byte_valid  = 1'b1;
        i_byte_data   = 8'h6B;
        i_byte_last   = 1'b1;
        i_block_ready = 1'b1;
        tick();
        i_block_ready = 1'b0;
        chk("same_cycle_bready", 64'(o_byte_ready), 64'd1);
        chk("same_cycle_data", o_block_data, 64'h0);
        tick();
        i_byte_valid = 1'b0;
        i_byte_last  = 1'b0;
        take_block("after_same", 64'h6B80000000000000, 1'b1, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ascon_block_padder

`default_nettype wire
